// File: rtl/gate_table_sequencer_if.sv
// rtl/gate_table_sequencer_if.sv - bus bundle between the truth-table sequencer and its user
//
// Purpose: groups the sweep request, the gate-unit drive/result lines and
// the captured-table status so a single port carries the whole block bus.
// Signals:
//   start       sweep request (level, honoured only while idle)
//   gate_a/b    drive lines to the two-input gate unit
//   gate_res    gate unit results {and, nand, nor, or, xnor, xor}
//   truth_table captured table, combo k in bits [6k+5:6k]
//   err_mask    per-combo mismatch against the golden table
//   busy/done   sweep in progress / one-cycle completion pulse
// Modports: slave = sequencer side, master = requester / gate-unit side.
interface gate_table_sequencer_if;
    logic        start;
    logic        gate_a;
    logic        gate_b;
    logic [5:0]  gate_res;
    logic [23:0] truth_table;
    logic [3:0]  err_mask;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  gate_res,
        output gate_a,
        output gate_b,
        output truth_table,
        output err_mask,
        output busy,
        output done
    );

    modport master (
        output start,
        output gate_res,
        input  gate_a,
        input  gate_b,
        input  truth_table,
        input  err_mask,
        input  busy,
        input  done
    );
endinterface

// File: rtl/gate_table_sequencer.sv
// rtl/gate_table_sequencer.sv - sweeps a two-input gate unit through all inputs and captures its truth table
//
// Purpose: on start, drives the four {a,b} combinations in order, holds each
// for SETTLE cycles, samples the six gate results for one cycle, stores them
// in the table and flags any slot that differs from the golden table.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  gate_table_sequencer_if.slave (start, gate_a/b, gate_res,
//        truth_table, err_mask, busy, done)
// Parameter: SETTLE = hold cycles per combination before sampling (1..15).
module gate_table_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    gate_table_sequencer_if.slave  bus
);

    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    // Expected results for an ideal gate unit, slot k in bits [6k+5:6k].
    localparam logic [23:0] GOLDEN_TABLE = {6'b100110, 6'b010101, 6'b010101, 6'b011010};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  combo_q, combo_d;
    logic [3:0]  settle_q, settle_d;
    logic [23:0] table_q, table_d;
    logic [3:0]  err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            combo_q  <= 2'd0;
            settle_q <= 4'd0;
            table_q  <= 24'd0;
            err_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            combo_q  <= combo_d;
            settle_q <= settle_d;
            table_q  <= table_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        combo_d  = combo_q;
        settle_d = settle_q;
        table_d  = table_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                // The table is left alone here so a previous result stays
                // readable; only the error flags restart from clean.
                if (bus.start) begin
                    state_d  = ST_DRIVE;
                    combo_d  = 2'd0;
                    settle_d = SETTLE_V;
                    err_d    = 4'd0;
                end
            end
            ST_DRIVE: begin
                settle_d = settle_q - 4'd1;
                // settle_q == 1 marks the last hold cycle of this combination.
                if (settle_q <= 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                for (int k = 0; k < 4; k++) begin
                    if (combo_q == 2'(k)) begin
                        table_d[6*k +: 6] = bus.gate_res;
                        if (bus.gate_res != GOLDEN_TABLE[6*k +: 6]) begin
                            err_d[k] = 1'b1;
                        end
                    end
                end
                if (combo_q == 2'd3) begin
                    state_d = ST_DONE;
                    combo_d = 2'd0;
                end else begin
                    state_d  = ST_DRIVE;
                    combo_d  = combo_q + 2'd1;
                    settle_d = SETTLE_V;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic driving;
    assign driving = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

    assign bus.gate_a      = driving & combo_q[1];
    assign bus.gate_b      = driving & combo_q[0];
    assign bus.busy        = driving;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.truth_table = table_q;
    assign bus.err_mask    = err_q;

endmodule

// File: tb/tb_gate_table_sequencer.sv
// tb/tb_gate_table_sequencer.sv - scoreboard bench for gate_table_sequencer
module tb_gate_table_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_table_sequencer_if bus1();
    gate_table_sequencer_if bus2();

    gate_table_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    gate_table_sequencer #(.SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct {
        int          done_cyc;
        logic [23:0] tbl;
        logic [3:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   rd_idx    = 0;
    int   cyc       = 0;
    int   mode      = 0;
    int   e0_1      = -100;
    bit   act1      = 1'b0;
    int   e0_2      = 0;
    bit   act2      = 1'b0;
    bit   fin_req   = 1'b0;
    int   checks    = 0;
    int   failures  = 0;
    int   done2_cnt = 0;

    function automatic logic [5:0] ideal_res(input logic a, input logic b);
        return {a & b, ~(a & b), ~(a | b), a | b, ~(a ^ b), a ^ b};
    endfunction

    function automatic logic [5:0] faulty_res(input logic a, input logic b);
        return {a & b, a & ~b, a | ~b, a | b, ~(a ^ b), a ^ b};
    endfunction

    assign bus2.gate_res = ideal_res(bus2.gate_a, bus2.gate_b);

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Gate unit for dut1: ideal, faulty, or random except in SAMPLE cycles.
    initial forever begin
        int p;
        logic [5:0] r;
        @(negedge clk);
        p = cyc - e0_1 + 1;
        if (mode == 1) r = faulty_res(bus1.gate_a, bus1.gate_b);
        else           r = ideal_res(bus1.gate_a, bus1.gate_b);
        if (mode == 2 && !(act1 && p >= 1 && p <= 8 && (p % 2) == 0))
            r = 6'($urandom);
        bus1.gate_res = r;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: per-cycle drive/busy model plus scoreboard on each done pulse.
    initial forever begin
        int p, d, idx;
        logic [1:0] eg;
        logic eb, ed;
        @(negedge clk);
        if (rst) begin
            chk("rst_dut1_outputs",
                {bus1.gate_a, bus1.gate_b, bus1.busy, bus1.done, bus1.err_mask, bus1.truth_table}, 32'd0);
            chk("rst_dut2_outputs",
                {bus2.gate_a, bus2.gate_b, bus2.busy, bus2.done, bus2.err_mask, bus2.truth_table}, 32'd0);
            rd_idx = sb_q.size();
        end else begin
            p  = cyc - e0_1 + 1;
            eb = act1 && p >= 1 && p <= 8;
            eg = eb ? 2'((p - 1) / 2) : 2'd0;
            chk("dut1_busy", 32'(bus1.busy), 32'(eb));
            chk("dut1_gates", 32'({bus1.gate_a, bus1.gate_b}), 32'(eg));
            if (bus1.done) begin
                chk("dut1_done_pending", 32'(rd_idx < sb_q.size()), 32'd1);
                if (rd_idx < sb_q.size()) begin
                    chk("dut1_done_cycle", cyc, sb_q[rd_idx].done_cyc);
                    chk("dut1_table", 32'(bus1.truth_table), 32'(sb_q[rd_idx].tbl));
                    chk("dut1_err_mask", 32'(bus1.err_mask), 32'(sb_q[rd_idx].err));
                    rd_idx = rd_idx + 1;
                end
            end

            eb = 1'b0;
            ed = 1'b0;
            eg = 2'd0;
            if (act2 && cyc >= e0_2) begin
                d   = cyc - e0_2;
                idx = d / 18;
                p   = (d % 18) + 1;
                if (idx < 3) begin
                    eb = (p <= 16);
                    ed = (p == 17);
                    eg = eb ? 2'((p - 1) / 4) : 2'd0;
                end
            end
            chk("dut2_busy", 32'(bus2.busy), 32'(eb));
            chk("dut2_done", 32'(bus2.done), 32'(ed));
            chk("dut2_gates", 32'({bus2.gate_a, bus2.gate_b}), 32'(eg));
            if (bus2.done) done2_cnt = done2_cnt + 1;
        end
        if (fin_req) begin
            chk("sb_drained", rd_idx, sb_q.size());
            chk("dut2_done_count", done2_cnt, 3);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic launch1(input int m, input logic [23:0] t, input logic [3:0] e);
        @(negedge clk);
        mode       = m;
        bus1.start = 1'b1;
        e0_1       = cyc + 1;
        act1       = 1'b1;
        sb_q.push_back('{done_cyc: cyc + 9, tbl: t, err: e});
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    initial begin
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Ideal gate unit, single-cycle start pulse.
        launch1(0, 24'h99555A, 4'h0);
        repeat (10) @(negedge clk);

        // Faulty nand/nor: every slot mismatches.
        launch1(1, 24'hB9D14A, 4'hF);
        repeat (10) @(negedge clk);

        // Random gate_res outside SAMPLE; also proves err_mask clears on start.
        launch1(2, 24'h99555A, 4'h0);
        repeat (10) @(negedge clk);

        // Extra start pulse in C3 must be ignored.
        launch1(0, 24'h99555A, 4'h0);
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (14) @(negedge clk);

        // Reset asserted early in C5 aborts the sweep with no done.
        launch1(0, 24'h99555A, 4'h0);
        repeat (4) @(posedge clk);
        #2;
        rst  = 1'b1;
        act1 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        launch1(0, 24'h99555A, 4'h0);
        repeat (10) @(negedge clk);

        // SETTLE=3 with start held high: back-to-back sweeps, 18-cycle period.
        @(negedge clk);
        bus2.start = 1'b1;
        e0_2       = cyc + 1;
        act2       = 1'b1;
        repeat (40) @(negedge clk);
        bus2.start = 1'b0;
        repeat (25) @(negedge clk);

        fin_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
